// File: rtl/if_stage.sv
// Instruction fetch stage of the 5-stage RV32 pipeline.
// Owns the PC and keeps at most one request in flight on the req/gnt/rvalid
// instruction-memory port. A single-entry skid buffer catches a response
// that lands while decode is stalled. A redirect from execute flushes the
// stage, and kill_r drops the stale response that is still in flight.
module if_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            id_valid_o,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_plus4_o
);

   localparam logic [0:0]      ST_IDLE = 1'b0;  // no outstanding request
   localparam logic [0:0]      ST_WAIT = 1'b1;  // granted, awaiting rvalid
   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

   logic [0:0]      state_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pend_pc_r;
   logic            kill_r;
   logic            skid_valid_r;
   logic [XLEN-1:0] skid_pc_r;
   logic [XLEN-1:0] skid_instr_r;
   logic            id_valid_r;
   logic [XLEN-1:0] id_pc_r;
   logic [XLEN-1:0] id_instr_r;
   logic [XLEN-1:0] id_pc_plus4_r;

   logic            req_s;
   logic            fire_s;       // request accepted this cycle
   logic            done_s;       // outstanding request completes this cycle
   logic            rsp_s;        // completing response is live (not killed)
   logic [XLEN-1:0] target_pc_s;  // word-aligned redirect target

   assign done_s      = (state_r == ST_WAIT) && imem_rvalid_i;
   assign rsp_s       = done_s && !kill_r;
   assign fire_s      = req_s && imem_gnt_i;
   assign target_pc_s = {redirect_pc_i[XLEN-1:2], 2'b00};

   // Request decision: a new fetch may overlap the completing one, but never
   // during redirect, while the skid holds data, or on a killed response.
   always_comb begin
      req_s = 1'b0;
      if (!rst_ni || redirect_i || skid_valid_r) begin
         req_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: req_s = 1'b1;
            ST_WAIT: req_s = imem_rvalid_i && !kill_r && !(stall_i && id_valid_r);
            default: req_s = 1'b0;
         endcase
      end
   end

   assign imem_req_o  = req_s;
   assign imem_addr_o = pc_r;

   // PC, outstanding-request FSM and kill tracking; redirect has priority.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= ST_IDLE;
         pc_r      <= RESET_PC;
         pend_pc_r <= ZERO;
         kill_r    <= 1'b0;
      end else if (redirect_i) begin
         pc_r <= target_pc_s;
         if (done_s) begin
            // in-flight response arrives now and is simply discarded
            state_r <= ST_IDLE;
            kill_r  <= 1'b0;
         end else if (state_r == ST_WAIT) begin
            kill_r <= 1'b1;
         end else begin
            kill_r <= kill_r;
         end
      end else if (fire_s) begin
         pend_pc_r <= pc_r;
         pc_r      <= pc_r + PC_STEP;
         state_r   <= ST_WAIT;
         kill_r    <= 1'b0;
      end else if (done_s) begin
         state_r <= ST_IDLE;
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_r;
      end
   end

   // IF/ID register and skid buffer: stall holds IF/ID, redirect flushes both.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_valid_r  <= 1'b0;
         skid_pc_r     <= ZERO;
         skid_instr_r  <= ZERO;
         id_valid_r    <= 1'b0;
         id_pc_r       <= ZERO;
         id_instr_r    <= ZERO;
         id_pc_plus4_r <= ZERO;
      end else if (redirect_i) begin
         id_valid_r   <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (stall_i && id_valid_r) begin
         // decode is holding a real instruction: park a live response
         if (rsp_s) begin
            skid_valid_r <= 1'b1;
            skid_pc_r    <= pend_pc_r;
            skid_instr_r <= imem_rdata_i;
         end else begin
            skid_valid_r <= skid_valid_r;
         end
      end else if (skid_valid_r) begin
         id_valid_r    <= 1'b1;
         id_pc_r       <= skid_pc_r;
         id_instr_r    <= skid_instr_r;
         id_pc_plus4_r <= skid_pc_r + PC_STEP;
         skid_valid_r  <= 1'b0;
      end else if (rsp_s) begin
         id_valid_r    <= 1'b1;
         id_pc_r       <= pend_pc_r;
         id_instr_r    <= imem_rdata_i;
         id_pc_plus4_r <= pend_pc_r + PC_STEP;
      end else if (!stall_i) begin
         id_valid_r <= 1'b0;
      end else begin
         id_valid_r <= id_valid_r;
      end
   end

   assign id_valid_o    = id_valid_r;
   assign id_pc_o       = id_pc_r;
   assign id_instr_o    = id_instr_r;
   assign id_pc_plus4_o = id_pc_plus4_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small instruction-memory model grants in
// the request cycle and answers after a programmable latency of 1 or 2
// cycles, returning rdata = addr ^ KEY so each instruction identifies its PC.
module tb_if_stage;

   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic        clk_i;
   logic        rst_ni;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_plus4_o;

   int checks;
   int errors;

   // memory model state
   logic        gnt_en;
   int          lat;
   logic        mem_pend;
   logic [1:0]  mem_cnt;
   logic [31:0] mem_addr;

   if_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .id_valid_o    (id_valid_o),
      .id_pc_o       (id_pc_o),
      .id_instr_o    (id_instr_o),
      .id_pc_plus4_o (id_pc_plus4_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   assign imem_gnt_i    = imem_req_o & gnt_en;
   assign imem_rvalid_i = mem_pend && (mem_cnt == 2'd0);
   assign imem_rdata_i  = imem_rvalid_i ? (mem_addr ^ KEY) : 32'h0000_0000;

   // memory model: one outstanding access, response after lat cycles
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_pend <= 1'b0;
         mem_cnt  <= 2'd0;
         mem_addr <= 32'h0000_0000;
      end else begin
         if (imem_rvalid_i) begin
            mem_pend <= 1'b0;
         end else if (mem_pend) begin
            mem_cnt <= mem_cnt - 2'd1;
         end
         if (imem_req_o && imem_gnt_i) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_addr_o;
            mem_cnt  <= (lat == 2) ? 2'd1 : 2'd0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk_i);
   endtask

   task automatic id_expect(input string tag, input logic [31:0] pc);
      check({tag, ".valid"}, {31'd0, id_valid_o}, 32'd1);
      check({tag, ".pc"}, id_pc_o, pc);
      check({tag, ".instr"}, id_instr_o, pc ^ KEY);
      check({tag, ".pc4"}, id_pc_plus4_o, pc + 32'd4);
   endtask

   task automatic req_expect(input string tag, input logic req, input logic [31:0] addr);
      check({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
      if (req) check({tag, ".addr"}, imem_addr_o, addr);
   endtask

   task automatic bubble_expect(input string tag);
      check({tag, ".valid"}, {31'd0, id_valid_o}, 32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_ni        = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0000_0000;
      gnt_en        = 1'b1;
      lat           = 1;

      // reset values
      repeat (2) cyc();
      #1;
      check("rst.req", {31'd0, imem_req_o}, 32'd0);
      check("rst.valid", {31'd0, id_valid_o}, 32'd0);
      check("rst.pc", id_pc_o, 32'h0);
      check("rst.instr", id_instr_o, 32'h0);
      check("rst.pc4", id_pc_plus4_o, 32'h0);

      // 1: back-to-back fetch from RESET_PC
      cyc(); rst_ni = 1'b1; #1;
      req_expect("c0", 1'b1, 32'h100); bubble_expect("c0");
      cyc(); #1;
      req_expect("c1", 1'b1, 32'h104); bubble_expect("c1");
      cyc(); #1;
      id_expect("c2", 32'h100); req_expect("c2", 1'b1, 32'h108);

      // 2: stall three cycles with 0x104 in IF/ID
      cyc(); stall_i = 1'b1; #1;
      id_expect("c3", 32'h104); req_expect("c3", 1'b0, 32'h0);
      cyc(); #1;
      id_expect("c4", 32'h104); req_expect("c4.skid", 1'b0, 32'h0);
      cyc(); #1;
      id_expect("c5", 32'h104); req_expect("c5.skid", 1'b0, 32'h0);
      cyc(); stall_i = 1'b0; #1;
      id_expect("c6", 32'h104); req_expect("c6.skid", 1'b0, 32'h0);
      cyc(); lat = 2; #1;
      id_expect("c7", 32'h108); req_expect("c7", 1'b1, 32'h10C);

      // 3: redirect while 0x10C is outstanding (slow response)
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; #1;
      req_expect("c8.redir", 1'b0, 32'h0); bubble_expect("c8");
      cyc(); redirect_i = 1'b0; #1;
      req_expect("c9.kill", 1'b0, 32'h0); bubble_expect("c9");
      cyc(); lat = 1; #1;
      req_expect("c10", 1'b1, 32'h200); bubble_expect("c10.drop");
      cyc(); #1;
      req_expect("c11", 1'b1, 32'h204); bubble_expect("c11");
      cyc(); #1;
      id_expect("c12", 32'h200);

      // 4: redirect together with stall while the skid is full
      stall_i = 1'b1; #1;
      req_expect("c12.stall", 1'b0, 32'h0);
      cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300; #1;
      id_expect("c13", 32'h200); req_expect("c13", 1'b0, 32'h0);
      cyc(); redirect_i = 1'b0; stall_i = 1'b0; #1;
      bubble_expect("c14"); req_expect("c14", 1'b1, 32'h300);
      cyc(); #1;
      bubble_expect("c15.noskid"); req_expect("c15", 1'b1, 32'h304);
      cyc(); #1;
      id_expect("c16", 32'h300);

      // 5: grant withheld for four cycles
      gnt_en = 1'b0; #1;
      req_expect("c16.nog", 1'b1, 32'h308);
      cyc(); #1;
      req_expect("c17.nog", 1'b1, 32'h308); id_expect("c17", 32'h304);
      cyc(); #1;
      req_expect("c18.nog", 1'b1, 32'h308); bubble_expect("c18");
      cyc(); #1;
      req_expect("c19.nog", 1'b1, 32'h308); bubble_expect("c19");
      cyc(); gnt_en = 1'b1; #1;
      req_expect("c20", 1'b1, 32'h308);
      cyc(); #1;
      req_expect("c21", 1'b1, 32'h30C); bubble_expect("c21");
      cyc(); #1;
      id_expect("c22", 32'h308);

      // 6: PC wrap and unaligned redirect target
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
      req_expect("c22.redir", 1'b0, 32'h0);
      cyc(); redirect_i = 1'b0; #1;
      bubble_expect("c23"); req_expect("c23", 1'b1, 32'hFFFF_FFFC);
      cyc(); #1;
      req_expect("c24.wrap", 1'b1, 32'h0000_0000);
      cyc(); #1;
      id_expect("c25", 32'hFFFF_FFFC);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203; #1;
      req_expect("c25.redir", 1'b0, 32'h0);
      cyc(); redirect_i = 1'b0; #1;
      req_expect("c26.align", 1'b1, 32'h200); bubble_expect("c26");
      cyc(); #1;
      bubble_expect("c27");
      cyc(); #1;
      id_expect("c28", 32'h200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
